alu_issue: RTL

Operand-issue stage directly upstream of the ALU in the execute path. It accepts decoded ALU operations with register-file operands through a valid/ready handshake, buffers them in a two-entry skid buffer, and drives the ALU opcode and operand inputs plus the destination register index. Optionally, it replaces stale register operands with values bypassed from writeback.

---
 rtl/alu_issue.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// Operand-issue stage in front of the ALU: two-entry skid buffer (main + skid slot)
// with optional writeback bypass, enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4,
    parameter int RW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_com,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [RW-1:0]    in_rs0,
    input  logic [RW-1:0]    in_rs1,
    input  logic             in_use0,
    input  logic             in_use1,
    input  logic [RW-1:0]    in_rd,
    input  logic             fwd_valid,
    input  logic [RW-1:0]    fwd_rd,
    input  logic [WIDTH-1:0] fwd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPW-1:0]   alu_com,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    output logic [RW-1:0]    out_rd
);

    typedef struct packed {
        logic [OPW-1:0]   com;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [RW-1:0]    rs0;
        logic [RW-1:0]    rs1;
        logic             use0;
        logic             use1;
        logic [RW-1:0]    rd;
    } entry_t;

    entry_t m_q, s_q;
    entry_t in_e, in_f, m_f, s_f;
    logic   m_valid, s_valid, in_ready_q;
    logic   accept, drain;

`ifdef ALU_ISSUE_FWD_EN
    function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] v,
                                              input logic [RW-1:0] rs,
                                              input logic from_reg,
                                              input logic fv,
                                              input logic [RW-1:0] frd,
                                              input logic [WIDTH-1:0] fd);
        return (fv && from_reg && (rs == frd) && (rs != '0)) ? fd : v;
    endfunction

    function automatic entry_t bypass(input entry_t e,
                                      input logic fv,
                                      input logic [RW-1:0] frd,
                                      input logic [WIDTH-1:0] fd);
        entry_t r;
        r   = e;
        r.a = pick(e.a, e.rs0, e.use0, fv, frd, fd);
        r.b = pick(e.b, e.rs1, e.use1, fv, frd, fd);
        return r;
    endfunction
`else
    function automatic entry_t bypass(input entry_t e,
                                      input logic fv,
                                      input logic [RW-1:0] frd,
                                      input logic [WIDTH-1:0] fd);
        entry_t r;
        r = e;
        if (fv && (frd != frd) && (fd != fd)) r = '0;
        return r;
    endfunction

    logic unused_fwd;
    assign unused_fwd = ^{m_q.rs0, m_q.rs1, m_q.use0, m_q.use1};
`endif

    always_comb begin
        in_e      = '0;
        in_e.com  = in_com;
        in_e.a    = in_a;
        in_e.b    = in_b;
        in_e.rs0  = in_rs0;
        in_e.rs1  = in_rs1;
        in_e.use0 = in_use0;
        in_e.use1 = in_use1;
        in_e.rd   = in_rd;
        in_f      = bypass(in_e, fwd_valid, fwd_rd, fwd_data);
        m_f       = bypass(m_q, fwd_valid, fwd_rd, fwd_data);
        s_f       = bypass(s_q, fwd_valid, fwd_rd, fwd_data);
    end

    assign accept = in_valid && in_ready_q;
    assign drain  = m_valid && out_ready;

    // Held entries refresh every cycle so stalled operands see later writebacks.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q        <= '0;
            s_q        <= '0;
            m_valid    <= 1'b0;
            s_valid    <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            m_q <= m_f;
            s_q <= s_f;
            if (s_valid) begin
                if (drain) begin
                    m_q        <= s_f;
                    s_valid    <= 1'b0;
                    in_ready_q <= 1'b1;
                end
            end else if (accept) begin
                if (!m_valid || drain) begin
                    m_q     <= in_f;
                    m_valid <= 1'b1;
                end else begin
                    s_q        <= in_f;
                    s_valid    <= 1'b1;
                    in_ready_q <= 1'b0;
                end
            end else if (drain) begin
                m_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = m_valid;
    assign alu_com   = m_q.com;
    assign alu_in0   = m_q.a;
    assign alu_in1   = m_q.b;
    assign out_rd    = m_q.rd;

endmodule
